// File: rtl/mlt_pkg.sv
// Shared constants for the RV32I multicycle control path.
// Holds the major opcode values (also used by the instruction decoder) and the
// control-sequencer state encodings, plus a helper that flags supported opcodes.
package mlt_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 3;

  // RV32I major opcodes, inst[6:0]
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  // Sequencer state encodings (visible on the debug state port)
  localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] S_WB     = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

  // True for every opcode the sequencer knows how to execute
  function automatic logic opc_supported(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mlt_ack_timer.sv
// Bus-handshake wait timer.
// Counts cycles spent waiting for a memory acknowledge and flags expiry when the
// wait reaches TIMEOUT cycles without an ack (TIMEOUT=0 disables expiry).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - a state transition happens this cycle; restart from zero
//   waiting   - sequencer is in a state that waits on a handshake
//   ack       - acknowledge seen this cycle (active-high here)
//   expired   - combinational: last allowed wait cycle passed without ack
module mlt_ack_timer
  import mlt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Count unacknowledged wait cycles; zero outside waiting states
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !waiting) begin
      cnt_d = '0;
    end else if (!ack) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the final cycle wins over expiry
  assign expired = (TIMEOUT != 0) && waiting && !ack && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mlt_ctrl_fsm.sv
// Multicycle control sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
// enables, handles the active-low instruction/data acknowledges and halts on a
// handshake timeout.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   opcode            - inst[6:0] from IR, valid from DECODE onward
//   ACKI_n, ACKD_n    - instruction / data memory acknowledge, active-low
//   imem_req, mreq,
//   write, halted     - decoded from state
//   ir_en, mdr_en,
//   pc_en, rf_we,
//   illegal, bus_err  - same-cycle strobes from state plus ack/opcode
//   state             - current state encoding (debug)
//   retired           - completed-instruction count, wraps
module mlt_ctrl_fsm
  import mlt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             ACKI_n,
  input  logic             ACKD_n,
  output logic             imem_req,
  output logic             mreq,
  output logic             write,
  output logic             ir_en,
  output logic             mdr_en,
  output logic             pc_en,
  output logic             rf_we,
  output logic             illegal,
  output logic             bus_err,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               waiting, ack, expired, is_store;

  assign is_store = (opcode == OPC_STORE);
  assign waiting  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack      = (state_q == S_FETCH) ? !ACKI_n : !ACKD_n;

  mlt_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != state_q),
    .waiting (waiting),
    .ack     (ack),
    .expired (expired)
  );

  // Next state and same-cycle strobes
  always_comb begin
    state_d = state_q;
    ir_en   = 1'b0;
    mdr_en  = 1'b0;
    pc_en   = 1'b0;
    rf_we   = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (ack) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          bus_err = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        if (opc_supported(opcode)) begin
          state_d = S_EXEC;
        end else begin
          // Unknown opcode: skip it without counting it as retired
          illegal = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (opcode == OPC_BRANCH) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if ((opcode == OPC_LOAD) || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (ack) begin
          if (is_store) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_en  = 1'b1;
            state_d = S_WB;
          end
        end else if (expired) begin
          bus_err = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Reset aborts the instruction in flight: no strobes in the reset cycle
    if (rst) begin
      state_d = S_FETCH;
      ir_en   = 1'b0;
      mdr_en  = 1'b0;
      pc_en   = 1'b0;
      rf_we   = 1'b0;
      illegal = 1'b0;
      bus_err = 1'b0;
    end
  end

  // Retire on every PC update that is not an illegal-opcode skip
  always_comb begin
    retired_d = retired_q;
    if (pc_en && !illegal) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req = (state_q == S_FETCH);
  assign mreq     = (state_q == S_MEM);
  assign write    = (state_q == S_MEM) && is_store;
  assign halted   = (state_q == S_HALT);
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_mlt_ctrl_fsm.sv
// Self-checking bench for mlt_ctrl_fsm: directed vector table, hand-written
// timeout/reset sequences, then random traffic against an instruction-level model.
module tb_mlt_ctrl_fsm;

  localparam int unsigned TO   = 16;
  localparam int unsigned CW   = 32;
  localparam logic [6:0]  OP_A = 7'b0110011; // ADD (OP)
  localparam logic [6:0]  OP_L = 7'b0000011; // LOAD
  localparam logic [6:0]  OP_S = 7'b0100011; // STORE
  localparam logic [6:0]  OP_B = 7'b1100011; // BRANCH
  localparam logic [6:0]  OP_X = 7'b1111111; // unknown

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          ACKI_n, ACKD_n;
  logic          imem_req, mreq, write, ir_en, mdr_en, pc_en, rf_we;
  logic          illegal, bus_err, halted;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  mlt_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ACKI_n(ACKI_n), .ACKD_n(ACKD_n),
    .imem_req(imem_req), .mreq(mreq), .write(write), .ir_en(ir_en),
    .mdr_en(mdr_en), .pc_en(pc_en), .rf_we(rf_we), .illegal(illegal),
    .bus_err(bus_err), .halted(halted), .state(state), .retired(retired)
  );

  int checks = 0;
  int errors = 0;

  // Output bits: {imem,mreq,write,ir,mdr,pc,rf,illegal,bus_err,halted}
  function automatic logic [9:0] outs();
    return {imem_req, mreq, write, ir_en, mdr_en, pc_en, rf_we, illegal, bus_err, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge and let combinational outputs settle
  task automatic drive(input logic r, input logic [6:0] o, input logic ai, input logic ad);
    @(negedge clk);
    rst = r; opcode = o; ACKI_n = ai; ACKD_n = ad;
    #1;
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic        acki;
    logic        ackd;
    logic [2:0]  st;
    logic [9:0]  o;
    logic [31:0] ret;
  } vec_t;

  vec_t vt[22];

  // Instruction-level reference model
  logic [6:0] legal_ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                               7'b0010111};
  int          m_stage;   // spec encoding: 0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,5 HALT
  int          m_todo[$]; // stages still to visit for the current instruction
  int          m_wait;
  logic [31:0] m_ret;

  function automatic bit is_legal(input logic [6:0] o);
    foreach (legal_ops[k]) if (legal_ops[k] == o) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    vt = '{
      '{OP_A, 1'b0, 1'b1, 3'd0, 10'b1001000000, 32'd0},
      '{OP_A, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd0},
      '{OP_A, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd0},
      '{OP_A, 1'b1, 1'b1, 3'd4, 10'b0000011000, 32'd0},
      '{OP_L, 1'b0, 1'b1, 3'd0, 10'b1001000000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd3, 10'b0100000000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd3, 10'b0100000000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd3, 10'b0100000000, 32'd1},
      '{OP_L, 1'b1, 1'b0, 3'd3, 10'b0100100000, 32'd1},
      '{OP_L, 1'b1, 1'b1, 3'd4, 10'b0000011000, 32'd1},
      '{OP_S, 1'b0, 1'b1, 3'd0, 10'b1001000000, 32'd2},
      '{OP_S, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd2},
      '{OP_S, 1'b1, 1'b1, 3'd2, 10'b0000000000, 32'd2},
      '{OP_S, 1'b1, 1'b0, 3'd3, 10'b0110010000, 32'd2},
      '{OP_X, 1'b0, 1'b1, 3'd0, 10'b1001000000, 32'd3},
      '{OP_X, 1'b1, 1'b1, 3'd1, 10'b0000010100, 32'd3},
      '{OP_B, 1'b1, 1'b1, 3'd0, 10'b1000000000, 32'd3},
      '{OP_B, 1'b0, 1'b1, 3'd0, 10'b1001000000, 32'd3},
      '{OP_B, 1'b1, 1'b1, 3'd1, 10'b0000000000, 32'd3},
      '{OP_B, 1'b1, 1'b1, 3'd2, 10'b0000010000, 32'd3}
    };

    rst = 1'b1; opcode = OP_A; ACKI_n = 1'b1; ACKD_n = 1'b1;
    drive(1'b1, OP_A, 1'b1, 1'b1);
    drive(1'b1, OP_A, 1'b1, 1'b1);

    // Directed table: ADD, LOAD with 3 waits, STORE, illegal, BRANCH
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, vt[i].opc, vt[i].acki, vt[i].ackd);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].o));
      check($sformatf("vec%0d_retired", i), retired, vt[i].ret);
    end

    // Fetch timeout: bus_err in the 16th FETCH cycle, then sticky HALT
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, OP_B, 1'b1, 1'b1);
      check($sformatf("to_berr%0d", i), 32'(bus_err), 32'(i == 15));
      check($sformatf("to_state%0d", i), 32'(state), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, OP_B, 1'b0, 1'b0);
      check("halt_state", 32'(state), 32'd5);
      check("halt_outs", 32'(outs()), 32'(10'b0000000001));
      check("halt_retired", retired, 32'd4);
    end
    drive(1'b1, OP_B, 1'b0, 1'b0);
    check("halt_rst_outs", 32'(outs()), 32'(10'b0000000001));

    // Ack arriving in the 16th wait cycle beats the timeout
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, OP_L, 1'b1, 1'b1);
      if (i == 0) begin
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_retired", retired, 32'd0);
      end
      check($sformatf("late_outs%0d", i), 32'(outs()), 32'(10'b1000000000));
    end
    drive(1'b0, OP_L, 1'b0, 1'b1);
    check("late_ack_outs", 32'(outs()), 32'(10'b1001000000));
    drive(1'b0, OP_L, 1'b1, 1'b1);
    check("late_ack_decode", 32'(state), 32'd1);
    drive(1'b0, OP_L, 1'b1, 1'b1);
    check("late_exec", 32'(state), 32'd2);
    drive(1'b0, OP_L, 1'b1, 1'b1);
    check("mem_wait_outs", 32'(outs()), 32'(10'b0100000000));

    // Reset while in MEM: no mdr_en despite the ack, FETCH next cycle
    drive(1'b1, OP_L, 1'b1, 1'b0);
    check("mem_rst_outs", 32'(outs()), 32'(10'b0100000000));
    drive(1'b0, OP_L, 1'b1, 1'b1);
    check("mem_rst_state", 32'(state), 32'd0);
    check("mem_rst_outs2", 32'(outs()), 32'(10'b1000000000));

    // Random traffic against the model
    drive(1'b1, OP_A, 1'b1, 1'b1);
    m_stage = 0; m_wait = 0; m_ret = '0; m_todo.delete();
    begin
      int         thr;
      int         halt_cyc;
      logic [6:0] o;
      thr = 60; halt_cyc = 0; o = OP_A;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        logic       r, ai, ad;
        logic [9:0] e;
        int         nxt;
        if (cyc % 50 == 0) begin
          case ($urandom_range(0, 2))
            0:       thr = 70;
            1:       thr = 30;
            default: thr = 0;
          endcase
        end
        halt_cyc = (m_stage == 5) ? halt_cyc + 1 : 0;
        r  = (halt_cyc > 3) || ($urandom_range(0, 299) == 0);
        ai = !($urandom_range(0, 99) < thr);
        ad = !($urandom_range(0, 99) < thr);
        if (m_stage == 0) begin
          if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 8)];
          else                          o = 7'($urandom);
        end
        drive(r, o, ai, ad);

        e   = '0;
        nxt = m_stage;
        e[9] = (m_stage == 0);
        e[8] = (m_stage == 3);
        e[7] = (m_stage == 3) && (o == OP_S);
        e[0] = (m_stage == 5);
        if (r) begin
          nxt = 0;
        end else begin
          case (m_stage)
            0: begin
              if (!ai) begin e[6] = 1'b1; nxt = 1; end
              else if (m_wait == TO - 1) begin e[1] = 1'b1; nxt = 5; end
            end
            1: begin
              if (is_legal(o)) begin
                m_todo.delete();
                m_todo.push_back(2);
                if (o == OP_L)      begin m_todo.push_back(3); m_todo.push_back(4); end
                else if (o == OP_S) m_todo.push_back(3);
                else if (o != OP_B) m_todo.push_back(4);
                nxt = m_todo.pop_front();
              end else begin
                e[4] = 1'b1; e[2] = 1'b1; nxt = 0;
              end
            end
            2, 3, 4: begin
              if (m_stage == 3 && ad) begin
                if (m_wait == TO - 1) begin e[1] = 1'b1; nxt = 5; end
              end else begin
                if (m_stage == 4) e[3] = 1'b1;
                if (m_stage == 3 && o == OP_L) e[5] = 1'b1;
                if (m_todo.size() == 0) begin e[4] = 1'b1; nxt = 0; end
                else nxt = m_todo.pop_front();
              end
            end
            default: ;
          endcase
        end

        check("rand_state", 32'(state), 32'(m_stage));
        check("rand_outs", 32'(outs()), 32'(e));
        check("rand_retired", retired, m_ret);

        if (r) begin
          m_ret = '0; m_wait = 0; m_todo.delete();
        end else begin
          if (e[4] && !e[2]) m_ret = m_ret + 32'd1;
          if (nxt != m_stage)                   m_wait = 0;
          else if (m_stage == 0 || m_stage == 3) m_wait = m_wait + 1;
        end
        m_stage = nxt;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlt_ctrl_fsm.md
Name: mlt_ctrl_fsm

Overview:
Multicycle control sequencer for the RV32I multicycle datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the per-state enables (PC, IR, MDR, register-file write). It owns the instruction and data memory handshakes on the active-low ACKI_n/ACKD_n lines and times out stalled bus cycles. It sits in the top level beside the decoder: the decoder supplies the opcode, and this block gates the strobes the datapath consumes.

Parameters:
TIMEOUT, 16, max cycles spent waiting for ACKI_n/ACKD_n before bus error; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  7  inst[6:0] from the instruction register, valid from DECODE onward
ACKI_n  in  1  instruction memory acknowledge, active-low
ACKD_n  in  1  data memory acknowledge, active-low
imem_req  out  1  instruction fetch request
mreq  out  1  data memory request (drives MREQ)
write  out  1  data memory write (drives WRITE)
ir_en  out  1  load IR from IDT
mdr_en  out  1  load memory data register from DDT
pc_en  out  1  update PC (datapath selects +4, branch or jump target)
rf_we  out  1  register-file write strobe
illegal  out  1  one-cycle pulse on unknown opcode
bus_err  out  1  one-cycle pulse on handshake timeout
halted  out  1  sticky; high in HALT state
state  out  3  current state encoding, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state, counters and the retired counter are registered.
- Reset: state=FETCH, wait counter=0, retired=0. After reset every strobe is 0 except imem_req, which goes to 1 because FETCH is entered. Reset at any point aborts the instruction in flight with no further strobes.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Output style: imem_req, mreq and write are Moore outputs decoded from state. ir_en, mdr_en, pc_en, rf_we, illegal and bus_err are combinational from state plus the ack/opcode inputs, and are valid within the same cycle.
- FETCH: imem_req=1. ACKI_n sampled low → ir_en=1 that cycle, next state DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. Supported opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode → illegal=1 and pc_en=1 (the instruction is skipped), next state FETCH, retired unchanged. Supported opcode → next state EXEC.
- EXEC: one cycle.
  - BRANCH: pc_en=1, next state FETCH.
  - LOAD/STORE: next state MEM.
  - All other supported opcodes: next state WB.
- MEM: mreq=1; write=1 for STORE, 0 for LOAD.
  - STORE with ACKD_n low: pc_en=1, next state FETCH.
  - LOAD with ACKD_n low: mdr_en=1, next state WB.
  - No ack: stay in MEM.
- WB: rf_we=1, pc_en=1, next state FETCH.
- retired increments on every cycle in which pc_en=1 and illegal=0. It wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on every state transition and held at 0 outside FETCH/MEM.
  - Increments in FETCH/MEM on each cycle without an ack.
  - If TIMEOUT>0 and the counter equals TIMEOUT-1 with no ack in that cycle: bus_err=1 for that cycle, next state HALT.
  - An ack arriving in that same cycle wins over the timeout (normal transition, no bus_err).
- HALT: all strobes 0, halted=1. The block leaves HALT only on rst.
- Fastest instruction latencies with zero-wait acks: BRANCH 3 cycles, ALU/jump/U-type 4, STORE 4, LOAD 5.

Decomposition:
- Shared package mlt_pkg holds the opcode localparams (OPC_LOAD … OPC_AUIPC) and the state encodings (S_FETCH … S_HALT). The decoder will reuse the opcode constants.
- One natural sub-module: mlt_ack_timer, which contains the wait counter and the timeout compare. Its ports are clk, rst, clear, waiting, ack and expired. Everything else stays in the FSM.

Test Plan:
- ADD (0110011) with ACKI_n low in the first FETCH cycle → states 0,1,2,4,0. ir_en in cycle 0; rf_we and pc_en in cycle 3; retired 0→1.
- LOAD with ACKD_n held high for 3 cycles in MEM → mreq=1, write=0 for 4 cycles. mdr_en only on the ack cycle, then rf_we in WB. Total 8 cycles.
- STORE → write=1 and mreq=1 in MEM. pc_en on the ack cycle, rf_we never asserted.
- Opcode 1111111 → illegal pulses in DECODE with pc_en=1. Next state FETCH, retired unchanged.
- TIMEOUT=16 with ACKI_n held high → bus_err pulses in the 16th FETCH cycle. halted=1 from the next cycle and stays high. rst for 1 cycle → state=0, retired=0.
- ACKI_n goes low exactly in the 16th wait cycle → no bus_err, normal transition to DECODE. Separately, assert rst while in MEM → FETCH next cycle with mreq=0.
